time_manager_multi: RTL and testbench

- Parametrised successor to the two-input time arbiter; the central emulation time base.
- Takes N per-channel proposed next-event times, each gated by an active flag.
- Selects the earliest active time and its channel index.
- Advances the registered global time under a start/pause/stop/clear control FSM, with step counting and a sticky backwards-time error.

---
 rtl/time_manager_multi.sv | 122 ++++++++++++
 tb/tb_time_manager_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_manager_multi.sv
// Central emulation time base: picks the earliest active proposed time among N
// channels and advances the registered global time under a start/pause/stop/clear FSM.
module time_manager_multi #(
    parameter int N          = 4,
    parameter int TIME_BITS  = 32,
    parameter int COUNT_BITS = 32,
    parameter int IDX_BITS   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys_n,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   clear,
    input  logic [TIME_BITS-1:0]   time_stop,
    input  logic [N*TIME_BITS-1:0] time_in,
    input  logic [N-1:0]           active,
    output logic [TIME_BITS-1:0]   time_next,
    output logic [IDX_BITS-1:0]    sel,
    output logic                   none_active,
    output logic [TIME_BITS-1:0]   time_curr,
    output logic [COUNT_BITS-1:0]  step_count,
    output logic                   running,
    output logic                   done,
    output logic                   err_backwards
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TIME_BITS-1:0]    r_time;
    logic [TIME_BITS-1:0]    w_time_nxt;
    logic [COUNT_BITS-1:0]   r_cnt;
    logic [COUNT_BITS-1:0]   w_cnt_nxt;
    logic                    r_err;
    logic                    w_err_nxt;
    logic                    r_running;
    logic                    r_done;

    logic [TIME_BITS-1:0]    w_min;
    logic [IDX_BITS-1:0]     w_sel;
    logic                    w_any;

    // Strict less-than keeps the lowest index on ties; w_any lets the first active
    // channel win even when its value is all ones.
    always_comb begin
        w_min = '1;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (active[i] && (!w_any || (time_in[i*TIME_BITS +: TIME_BITS] < w_min))) begin
                w_min = time_in[i*TIME_BITS +: TIME_BITS];
                w_sel = IDX_BITS'(i);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_time_nxt  = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (pause || !w_any) begin
                        w_state_nxt = S_RUN;
                    end else if (w_min > time_stop) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_time_nxt = w_min;
                        if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
                        if (w_min < r_time) w_err_nxt = 1'b1;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state   <= S_IDLE;
            r_time    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign time_next     = w_min;
    assign sel           = w_sel;
    assign none_active   = ~w_any;
    assign time_curr     = r_time;
    assign step_count    = r_cnt;
    assign running       = r_running;
    assign done          = r_done;
    assign err_backwards = r_err;

endmodule

// File: tb/tb_time_manager_multi.sv
// Bench for time_manager_multi: directed scenarios plus randomized traffic against
// an arithmetic reference model; also exercises a 4-bit counter and an N=1 instance.
module tb_time_manager_multi;

    logic         clk_sys = 1'b0;
    logic         rst_sys_n;
    logic         start, pause, clear;
    logic [31:0]  time_stop;
    logic [31:0]  tin [4];
    logic [3:0]   active;
    logic [127:0] time_in_bus;

    logic [31:0]  tn_a, tc_a, tn_b, tc_b, tn_c, tc_c;
    logic [1:0]   sel_a, sel_b;
    logic         sel_c;
    logic         na_a, na_b, na_c, run_a, run_b, run_c, dn_a, dn_b, dn_c, er_a, er_b, er_c;
    logic [31:0]  cnt_a, cnt_c;
    logic [3:0]   cnt_b;

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [31:0] m_time;
    longint      m_cnt;
    logic        m_err, m_run, m_done;

    assign time_in_bus = {tin[3], tin[2], tin[1], tin[0]};

    always #5 clk_sys = ~clk_sys;

    time_manager_multi #(.N(4), .TIME_BITS(32), .COUNT_BITS(32)) dut_a (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start(start), .pause(pause), .clear(clear),
        .time_stop(time_stop), .time_in(time_in_bus), .active(active),
        .time_next(tn_a), .sel(sel_a), .none_active(na_a), .time_curr(tc_a),
        .step_count(cnt_a), .running(run_a), .done(dn_a), .err_backwards(er_a));

    time_manager_multi #(.N(4), .TIME_BITS(32), .COUNT_BITS(4)) dut_b (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start(start), .pause(pause), .clear(clear),
        .time_stop(time_stop), .time_in(time_in_bus), .active(active),
        .time_next(tn_b), .sel(sel_b), .none_active(na_b), .time_curr(tc_b),
        .step_count(cnt_b), .running(run_b), .done(dn_b), .err_backwards(er_b));

    time_manager_multi #(.N(1), .TIME_BITS(32), .COUNT_BITS(32)) dut_c (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start(start), .pause(pause), .clear(clear),
        .time_stop(time_stop), .time_in(tin[0]), .active(active[0:0]),
        .time_next(tn_c), .sel(sel_c), .none_active(na_c), .time_curr(tc_c),
        .step_count(cnt_c), .running(run_c), .done(dn_c), .err_backwards(er_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Earliest active proposal: find the smallest value, then the first channel holding it.
    function automatic void ref_min(input int n, output logic [31:0] mn, output int idx, output bit none);
        longint best = 64'h1_0000_0000;
        idx = 0;
        for (int i = 0; i < n; i++)
            if (active[i] && tin[i] < best) best = tin[i];
        none = (best == 64'h1_0000_0000);
        mn = none ? 32'hFFFF_FFFF : best[31:0];
        if (!none)
            for (int i = n - 1; i >= 0; i--)
                if (active[i] && tin[i] == mn) idx = i;
    endfunction

    task automatic check_comb();
        logic [31:0] mn, mn1;
        int idx, idx1;
        bit none, none1;
        ref_min(4, mn, idx, none);
        ref_min(1, mn1, idx1, none1);
        chk("time_next", tn_a, mn);
        chk("sel", sel_a, idx);
        chk("none_active", na_a, none);
        chk("n1_time_next", tn_c, mn1);
        chk("n1_sel", sel_c, 0);
    endtask

    task automatic model_step();
        logic [31:0] mn;
        int idx;
        bit none;
        ref_min(4, mn, idx, none);
        if (clear) begin
            m_time = 0; m_cnt = 0; m_err = 0; m_run = 0; m_done = 0;
        end else if (!m_run && !m_done) begin
            if (start) m_run = 1;
        end else if (m_run && !pause && !none) begin
            if (mn > time_stop) begin
                m_run = 0; m_done = 1;
            end else begin
                if (mn < m_time) m_err = 1;
                m_time = mn;
                m_cnt++;
            end
        end
    endtask

    task automatic check_regs();
        chk("time_curr", tc_a, m_time);
        chk("step_count", cnt_a, m_cnt);
        chk("running", run_a, m_run);
        chk("done", dn_a, m_done);
        chk("err_backwards", er_a, m_err);
        chk("sat_step_count", cnt_b, (m_cnt > 15) ? 15 : m_cnt);
        chk("sat_time_curr", tc_b, m_time);
    endtask

    task automatic cycle();
        #1;
        check_comb();
        model_step();
        @(posedge clk_sys);
        #1;
        check_regs();
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 4; i++) tin[i] = v;
    endtask

    task automatic model_reset();
        m_time = 0; m_cnt = 0; m_err = 0; m_run = 0; m_done = 0;
    endtask

    initial begin
        rst_sys_n = 1'b0;
        start = 0; pause = 0; clear = 0;
        time_stop = 100; active = 4'b0000;
        set_all(0);
        model_reset();
        #2;
        check_regs();
        chk("n1_running_rst", run_c, 0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        @(posedge clk_sys); #1;

        // Earliest-of-four with a tie at 10: lowest index (1) wins
        tin[0] = 40; tin[1] = 10; tin[2] = 30; tin[3] = 10;
        active = 4'b1111; start = 1;
        cycle();
        start = 0;
        cycle();
        chk("t1_time_curr", tc_a, 10);

        // No active channels: hold
        active = 4'b0000;
        repeat (3) cycle();

        // Inclusive stop limit, then DONE; start ignored there
        active = 4'b1111;
        set_all(90); cycle();
        set_all(150); tin[2] = 100; cycle();
        chk("t3_at_stop", tc_a, 100);
        tin[2] = 101; cycle();
        chk("t3_done", dn_a, 1);
        start = 1; cycle(); start = 0;
        cycle();
        clear = 1; cycle(); clear = 0;

        // Backwards step sets the sticky error
        start = 1; cycle(); start = 0;
        set_all(50); cycle();
        set_all(20); cycle();
        chk("t4_err", er_a, 1);
        set_all(30); cycle();
        set_all(30); cycle();
        set_all(40); cycle();
        clear = 1; cycle(); clear = 0;
        chk("t4_cleared_err", er_a, 0);

        // Pause holds everything
        start = 1; cycle(); start = 0;
        set_all(5); cycle();
        pause = 1;
        for (int k = 0; k < 5; k++) begin set_all(6 + k); cycle(); end
        pause = 0; cycle();

        // Twenty advances: 4-bit counter saturates
        time_stop = 32'hFFFF_0000;
        for (int k = 0; k < 20; k++) begin set_all(100 + k); tin[3] = 99 + k; cycle(); end
        chk("t6_sat", cnt_b, 15);

        // Asynchronous reset between edges while running
        @(negedge clk_sys); #2;
        rst_sys_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        @(posedge clk_sys); #1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) tin[i] = (k % 3 == 0) ? $urandom : $urandom_range(0, 300);
            if ($urandom_range(0, 15) == 0) tin[$urandom_range(0, 3)] = 32'hFFFF_FFFF;
            active    = 4'($urandom);
            pause     = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 3) == 0);
            clear     = ($urandom_range(0, 24) == 0);
            time_stop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 250) : 32'hFFFF_FFFE;
            cycle();
        end
        start = 0; pause = 0; clear = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
